// File: rtl/life_pkg.sv
// life_pkg: constants and types shared by the Game of Life loader.
//   LIFE_MODE_HOLD / LIFE_MODE_EVOLVE : values for the engine's 2-bit `a` mode input
//   ROW_W                             : cells per grid row
//   life_state_t                      : loader FSM states {FILL, PRESENT, RUN}
package life_pkg;

  localparam logic [1:0] LIFE_MODE_HOLD   = 2'b00;
  localparam logic [1:0] LIFE_MODE_EVOLVE = 2'b10;

  localparam int ROW_W = 8;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PRESENT = 2'd1,
    RUN     = 2'd2
  } life_state_t;

endpackage

// File: rtl/life_grid_loader.sv
// life_grid_loader: serial front end for the Game of Life evolution engine.
// Collects the seed grid one row at a time, offers the packed grid to the
// engine, then holds the engine in evolve mode for GENS cycles.
//
// Handshakes:
//   rows : a row transfers on a rising edge where row_valid && row_ready
//          (and, with parity, the row has even parity). row_ready depends
//          only on the FSM state, never on row_valid.
//   grid : Grid is stable while grid_valid=1; the transfer completes on the
//          edge where grid_valid && grid_ack. grid_ack is ignored otherwise.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   row_in, row_valid   row data (bit 0 = leftmost cell) and its valid
//   row_ready           loader accepts a row this cycle (state == FILL)
//   Grid                packed grid, row k at [ROW_W*k +: ROW_W]
//   grid_valid, grid_ack  grid offer / engine acceptance
//   a                   engine mode (hold/load or evolve)
//   done                one-cycle pulse in the last evolve cycle
//   dbg_state, dbg_row_cnt  FSM state and row counter for observation
//   row_par, par_err    only with LIFE_LOADER_PARITY_EN: row parity bit and a
//                       sticky bad-parity flag cleared by reset or grid_ack
//
// Build option: define LIFE_LOADER_PARITY_EN to add even-parity checking of rows.
module life_grid_loader
  import life_pkg::*;
#(
  parameter int ROW_W  = life_pkg::ROW_W,
  parameter int N_ROWS = 8,
  parameter int GENS   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ROW_W-1:0]            row_in,
  input  logic                        row_valid,
  output logic                        row_ready,
`ifdef LIFE_LOADER_PARITY_EN
  input  logic                        row_par,
  output logic                        par_err,
`endif
  output logic [ROW_W*N_ROWS-1:0]     Grid,
  output logic                        grid_valid,
  input  logic                        grid_ack,
  output logic [1:0]                  a,
  output logic                        done,
  output life_state_t                 dbg_state,
  output logic [$clog2(N_ROWS)-1:0]   dbg_row_cnt
);

  localparam int RC_W = $clog2(N_ROWS);

  life_state_t     state;
  logic [RC_W-1:0] row_cnt;
  logic [7:0]      gen_cnt;
  logic            row_ok;

`ifdef LIFE_LOADER_PARITY_EN
  // Even parity over data plus parity bit.
  assign row_ok = ~(^{row_in, row_par});
`else
  assign row_ok = 1'b1;
`endif

  assign row_ready   = (state == FILL);
  assign dbg_state   = state;
  assign dbg_row_cnt = row_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      row_cnt    <= '0;
      gen_cnt    <= '0;
      Grid       <= '0;
      grid_valid <= 1'b0;
      a          <= LIFE_MODE_HOLD;
      done       <= 1'b0;
`ifdef LIFE_LOADER_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        FILL: begin
          if (row_valid && row_ok) begin
            Grid[row_cnt*ROW_W +: ROW_W] <= row_in;
            if (row_cnt == RC_W'(N_ROWS-1)) begin
              row_cnt    <= '0;
              grid_valid <= 1'b1;
              state      <= PRESENT;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
`ifdef LIFE_LOADER_PARITY_EN
          // A bad-parity row is consumed (row_ready stays 1) but not stored.
          if (row_valid && !row_ok) par_err <= 1'b1;
`endif
        end
        PRESENT: begin
          if (grid_ack) begin
            grid_valid <= 1'b0;
            a          <= LIFE_MODE_EVOLVE;
            gen_cnt    <= 8'(GENS-1);
            // With a single generation the first evolve cycle is also the last.
            done       <= (GENS == 1);
            state      <= RUN;
`ifdef LIFE_LOADER_PARITY_EN
            par_err    <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (gen_cnt == 8'd0) begin
            a     <= LIFE_MODE_HOLD;
            state <= FILL;
          end else begin
            gen_cnt <= gen_cnt - 1'b1;
            // done is registered, so raise it on the edge entering gen_cnt==0.
            if (gen_cnt == 8'd1) done <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_life_grid_loader.sv
// Testbench for life_grid_loader. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge, half a cycle from the active edge.
module tb_life_grid_loader;
  import life_pkg::*;

  localparam int N_ROWS = 8;
  localparam int GENS   = 4;
  localparam int GW     = ROW_W * N_ROWS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ROW_W-1:0]  row_in = '0;
  logic              row_valid = 1'b0;
  logic              row_ready;
  logic [GW-1:0]     grid;
  logic              grid_valid;
  logic              grid_ack = 1'b0;
  logic [1:0]        a;
  logic              done;
  life_state_t       dbg_state;
  logic [2:0]        dbg_row_cnt;
`ifdef LIFE_LOADER_PARITY_EN
  logic              row_par = 1'b0;
  logic              par_err;
`endif

  life_grid_loader #(.ROW_W(ROW_W), .N_ROWS(N_ROWS), .GENS(GENS)) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .row_valid(row_valid),
    .row_ready(row_ready),
`ifdef LIFE_LOADER_PARITY_EN
    .row_par(row_par), .par_err(par_err),
`endif
    .Grid(grid), .grid_valid(grid_valid), .grid_ack(grid_ack), .a(a),
    .done(done), .dbg_state(dbg_state), .dbg_row_cnt(dbg_row_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: rows in send order, and the grid content the loader should hold.
  logic [ROW_W-1:0] cur_rows [N_ROWS];
  logic [ROW_W-1:0] exp_q [$];
  logic [GW-1:0]    model_grid = '0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Loads cur_rows[first..N_ROWS-1]; rows before `first` must already be in model_grid.
  // gap_mode: 0 back to back, 1 valid every other cycle, 2 random gaps.
  task automatic load_grid(input int first, input int gap_mode);
    int k = first;
    int cyc = 0;
    logic go;
    logic [GW-1:0] exp_grid;
    exp_q.delete();
    for (int i = 0; i < N_ROWS; i++) exp_q.push_back(cur_rows[i]);
    exp_grid = '0;
    for (int i = 0; i < N_ROWS; i++) exp_grid[i*ROW_W +: ROW_W] = exp_q.pop_front();
    while (k < N_ROWS && cyc < 400) begin
      @(negedge clk);
      cyc++;
      n_checks++;
      if (row_ready !== 1'b1 || grid_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_flags: row_ready=%b grid_valid=%b, required 1/0 (row %0d)", row_ready, grid_valid, k);
      end
      n_checks++;
      if (grid !== model_grid) begin
        n_fail++;
        $display("FAIL fill_grid: Grid=%h required %h", grid, model_grid);
      end
      case (gap_mode)
        0:       go = 1'b1;
        1:       go = (cyc % 2 == 0);
        default: go = ($urandom_range(0, 2) != 0);
      endcase
      grid_ack = 1'($urandom_range(0, 1));  // must be ignored while filling
      if (go) begin
        row_valid = 1'b1;
        row_in    = cur_rows[k];
`ifdef LIFE_LOADER_PARITY_EN
        row_par   = ^cur_rows[k];
`endif
        model_grid[k*ROW_W +: ROW_W] = cur_rows[k];
        k++;
      end else begin
        row_valid = 1'b0;
        row_in    = ROW_W'($urandom);
      end
    end
    @(negedge clk);
    row_valid = 1'b0;
    grid_ack  = 1'b0;
    n_checks++;
    if (k < N_ROWS) begin
      n_fail++;
      $display("FAIL load_timeout: only %0d of %0d rows sent", k, N_ROWS);
    end
    n_checks++;
    if (grid_valid !== 1'b1 || row_ready !== 1'b0 || a !== LIFE_MODE_HOLD || dbg_state !== PRESENT) begin
      n_fail++;
      $display("FAIL present_flags: grid_valid=%b row_ready=%b a=%b state=%0d, required 1/0/00/PRESENT",
               grid_valid, row_ready, a, dbg_state);
    end
    n_checks++;
    if (grid !== exp_grid) begin
      n_fail++;
      $display("FAIL grid_value: Grid=%h required %h", grid, exp_grid);
    end
  endtask

  // From PRESENT: optional backpressure rows, ack, then the evolve window.
  task automatic run_grid(input logic bp);
    int hold = $urandom_range(1, 3);
    int evolve_cycles = 0;
    for (int h = 0; h < hold; h++) begin
      row_valid = bp;
      row_in    = 8'hFF;
      @(negedge clk);
      n_checks++;
      if (grid_valid !== 1'b1 || row_ready !== 1'b0 || a !== LIFE_MODE_HOLD || done !== 1'b0 || grid !== model_grid) begin
        n_fail++;
        $display("FAIL present_hold: grid_valid=%b row_ready=%b a=%b done=%b Grid=%h, required 1/0/00/0 Grid=%h",
                 grid_valid, row_ready, a, done, grid, model_grid);
      end
    end
    grid_ack = 1'b1;
    for (int c = 1; c <= GENS + 1; c++) begin
      @(negedge clk);
      grid_ack = 1'b0;
      if (a === LIFE_MODE_EVOLVE) evolve_cycles++;
      n_checks++;
      if (a !== ((c <= GENS) ? LIFE_MODE_EVOLVE : LIFE_MODE_HOLD) || done !== (c == GENS) ||
          row_ready !== (c > GENS) || grid_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL evolve_cycle%0d: a=%b done=%b row_ready=%b grid_valid=%b, required a=%b done=%b row_ready=%b grid_valid=0",
                 c, a, done, row_ready, grid_valid, (c <= GENS) ? LIFE_MODE_EVOLVE : LIFE_MODE_HOLD,
                 (c == GENS), (c > GENS));
      end
      n_checks++;
      if (grid !== model_grid) begin
        n_fail++;
        $display("FAIL evolve_grid: Grid=%h required %h", grid, model_grid);
      end
`ifdef LIFE_LOADER_PARITY_EN
      if (c == 1) begin
        n_checks++;
        if (par_err !== 1'b0) begin
          n_fail++;
          $display("FAIL par_err_ack_clear: par_err=%b required 0", par_err);
        end
      end
`endif
      if (c == GENS) row_valid = 1'b0;
    end
    n_checks++;
    if (evolve_cycles != GENS) begin
      n_fail++;
      $display("FAIL evolve_len: %0d evolve cycles, required %0d", evolve_cycles, GENS);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if (grid !== '0 || grid_valid !== 1'b0 || a !== LIFE_MODE_HOLD || done !== 1'b0 ||
        row_ready !== 1'b1 || dbg_row_cnt !== 3'd0 || dbg_state !== FILL) begin
      n_fail++;
      $display("FAIL %s: Grid=%h grid_valid=%b a=%b done=%b row_ready=%b row_cnt=%0d state=%0d, required all reset values",
               name, grid, grid_valid, a, done, row_ready, dbg_row_cnt, dbg_state);
    end
`ifdef LIFE_LOADER_PARITY_EN
    n_checks++;
    if (par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_par_err: par_err=%b required 0", name, par_err);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      row_valid = 1'b1;
      row_in    = ROW_W'($urandom);
      @(negedge clk);
      check_reset_values("reset_state");
    end
    row_valid  = 1'b0;
    reset      = 1'b0;
    model_grid = '0;
  endtask

  task automatic test_load();
    cur_rows = '{8'h28, 8'h3C, 8'h34, 8'h00, 8'h24, 8'h64, 8'h12, 8'h04};
    load_grid(0, 0);
    n_checks++;
    if (grid !== 64'h0412_6424_0034_3C28) begin
      n_fail++;
      $display("FAIL load_const: Grid=%h required 0412642400343c28", grid);
    end
    run_grid(1'b1);
  endtask

  task automatic test_gaps();
    cur_rows = '{8'h28, 8'h3C, 8'h34, 8'h00, 8'h24, 8'h64, 8'h12, 8'h04};
    load_grid(0, 1);
    n_checks++;
    if (grid !== 64'h0412_6424_0034_3C28) begin
      n_fail++;
      $display("FAIL gaps_const: Grid=%h required 0412642400343c28", grid);
    end
    run_grid(1'b0);
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < N_ROWS; i++) cur_rows[i] = ROW_W'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      row_valid = 1'b1;
      row_in    = cur_rows[i];
`ifdef LIFE_LOADER_PARITY_EN
      row_par   = ^cur_rows[i];
`endif
    end
    @(negedge clk);
    reset     = 1'b1;
    row_valid = 1'b1;
    row_in    = cur_rows[5];
    @(negedge clk);
    check_reset_values("reset_mid_fill");
    reset      = 1'b0;
    row_valid  = 1'b0;
    model_grid = '0;
    load_grid(0, 2);
    run_grid(1'b1);
  endtask

  task automatic test_reset_run();
    for (int i = 0; i < N_ROWS; i++) cur_rows[i] = ROW_W'($urandom);
    load_grid(0, 0);
    grid_ack = 1'b1;
    @(negedge clk);
    grid_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("reset_in_run");
    reset      = 1'b0;
    model_grid = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < N_ROWS; i++) cur_rows[i] = ROW_W'($urandom);
      load_grid(0, 2);
      run_grid(1'($urandom_range(0, 1)));
    end
  endtask

`ifdef LIFE_LOADER_PARITY_EN
  task automatic test_parity();
    for (int i = 0; i < N_ROWS; i++) cur_rows[i] = ROW_W'($urandom);
    cur_rows[0] = 8'h01;
    @(negedge clk);
    row_valid = 1'b1;
    row_in    = 8'h01;
    row_par   = 1'b0;
    @(negedge clk);
    n_checks++;
    if (par_err !== 1'b1 || dbg_row_cnt !== 3'd0 || grid !== model_grid) begin
      n_fail++;
      $display("FAIL parity_bad: par_err=%b row_cnt=%0d Grid=%h, required 1/0 Grid=%h",
               par_err, dbg_row_cnt, grid, model_grid);
    end
    row_par = 1'b1;
    @(negedge clk);
    row_valid = 1'b0;
    model_grid[ROW_W-1:0] = 8'h01;
    n_checks++;
    if (par_err !== 1'b1 || dbg_row_cnt !== 3'd1 || grid !== model_grid) begin
      n_fail++;
      $display("FAIL parity_good: par_err=%b row_cnt=%0d Grid=%h, required 1/1 Grid=%h",
               par_err, dbg_row_cnt, grid, model_grid);
    end
    load_grid(1, 0);
    n_checks++;
    if (par_err !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_sticky: par_err=%b required 1", par_err);
    end
    run_grid(1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_gaps();
    test_reset_mid_fill();
    test_random();
    test_reset_run();
`ifdef LIFE_LOADER_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
